can_rx_seq_ctrl: RTL and testbench
==================================

// Module: can_rx_seq_ctrl
// PURPOSE
//  Bit-timing and frame sequencer for the CAN receive datapath (can_rx).
//  Synchronises Can_rx, hard-syncs on SOF, resyncs on edges, and issues the one-clock R_frame sample tick.
//  Holds the receiver in reset until the bus is idle, bounds each frame, and times out a missing data-ready.
//  Hands the received byte to the UART side over a valid/ready handshake.
// PARAMETERS
//  BIT_CLKS    16  clocks per CAN bit (>=8)
//  SAMPLE_PT   11  phase index at which R_frame fires (1..BIT_CLKS-2)
//  SJW         2   max resync adjustment in clocks (1..4, < SAMPLE_PT)
//  IDLE_BITS   11  consecutive recessive samples that qualify the bus as idle
//  FRAME_BITS  96  ticks per frame, SOF tick included
//  DRAIN_BITS  8   ticks to wait for Can_data_ready after FRAME_BITS
// PORTS
//  clock            in   1  system clock
//  reset            in   1  asynchronous, active-low reset
//  enable           in   1  1 = run; 0 = force WAIT_IDLE
//  Can_rx           in   1  raw serial bus input (1 = recessive)
//  Can_data_ready   in   1  data-ready level from can_rx
//  Can_rx_data_Bus  in   8  data byte from can_rx
//  R_frame          out  1  one-clock sample tick to can_rx
//  rx_core_rst      out  1  active-high reset to can_rx
//  frame_active     out  1  1 in SOF/FRAME/DRAIN
//  byte_data        out  8  captured byte
//  byte_valid       out  1  byte_data valid; held until accepted
//  byte_ready       in   1  downstream accept
//  overrun          out  1  one-clock pulse when a byte is dropped
//  timeout_err      out  1  one-clock pulse on DRAIN timeout
// BEHAVIOUR
//  Reset values: R_frame=0, rx_core_rst=1, frame_active=0, byte_data=0, byte_valid=0, overrun=0, timeout_err=0.
//  Reset values (internal): state=WAIT_IDLE, phase=0, counters=0, sync flops=1.
//  Input sync: 2-flop synchroniser on Can_rx. Edges and samples use the synced value (2-clock latency).
//  Phase counter: 0..BIT_CLKS-1, wraps. Internal tick when phase==SAMPLE_PT. R_frame = tick in SOF/FRAME only.
//  Hard sync: a synced falling edge in IDLE -> next phase=1 (edge cycle is phase 0); state -> SOF.
//  Resync: FRAME only, on a recessive->dominant edge at phase p, at most once per bit.
//   - p in 1..SAMPLE_PT-1: next phase = p+1-min(p,SJW).
//   - p > SAMPLE_PT and (BIT_CLKS-p) <= SJW: next phase = 1.
//   - p > SAMPLE_PT otherwise: next phase = p+1+SJW.
//   - p==0 or p==SAMPLE_PT: no adjustment.
//  FSM:
//   - WAIT_IDLE: phase free-runs; count recessive ticks, a dominant tick clears the count.
//     Count==IDLE_BITS -> IDLE.
//   - IDLE: phase held 0; on falling edge -> SOF.
//   - SOF: at the first tick, dominant -> FRAME with bit_cnt=1.
//     Recessive is a glitch -> WAIT_IDLE.
//   - FRAME: bit_cnt increments per tick; the tick that makes bit_cnt==FRAME_BITS -> DRAIN.
//   - DRAIN: no R_frame. A rising edge of Can_data_ready captures Can_rx_data_Bus -> WAIT_IDLE.
//     DRAIN_BITS ticks without one -> timeout_err pulse -> WAIT_IDLE.
//   - enable=0 in any state -> WAIT_IDLE next clock; R_frame suppressed the same clock.
//  rx_core_rst is registered: 1 when next state is WAIT_IDLE or enable=0, else 0.
//   - Deasserts the clock after IDLE is entered.
//   - A glitch or timeout forces can_rx back to its idle state.
//  Byte handshake:
//   - Capture sets byte_valid=1 and byte_data. byte_valid clears on byte_valid&byte_ready.
//   - Capture with byte_valid=1 and byte_ready=0: new byte dropped, overrun pulse, byte_data kept.
//   - Capture with byte_valid=1 and byte_ready=1: new byte loaded, byte_valid stays 1, no overrun.
//  frame_active is registered from next state.
//  Reset mid-frame returns every output to its reset value immediately.
// TESTING (BIT_CLKS=16, SAMPLE_PT=11, SJW=2, defaults otherwise)
//  Startup: reset release, Can_rx=1 for 11 bits.
//   -> rx_core_rst falls after the 11th recessive tick; no R_frame.
//  SOF alignment: synced falling edge at cycle T.
//   -> R_frame at T+11, T+27, T+43.
//   -> Exactly 96 R_frame pulses, then frame_active=0 after DRAIN.
//  Resync: edge arrives 3 clocks late (p=3) -> next tick 2 clocks later than nominal.
//   Edge at p=15 -> phase restarts; next tick at edge+11.
//  Glitch: 4-clock dominant pulse in IDLE -> SOF tick samples recessive.
//   -> No further R_frame; rx_core_rst=1 and state WAIT_IDLE.
//  Handoff: Can_data_ready rises with bus=8'hA5 in DRAIN, byte_ready=0.
//   -> byte_valid=1, byte_data=8'hA5.
//   -> Second frame with 8'h3C while still unaccepted: overrun pulse, byte_data stays 8'hA5.
//  Timeout: Can_data_ready held 0 through DRAIN.
//   -> timeout_err pulse on the 8th DRAIN tick; rx_core_rst=1 the next clock.

Source files
------------

// File: rtl/can_rx_seq_ctrl_if.sv
// Byte handoff from the CAN receive sequencer to the UART side (valid/ready).
interface can_rx_seq_ctrl_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/can_rx_seq_ctrl.sv
// Bit-timing and frame sequencer for the CAN receive datapath: synchronises
// the bus, hard-syncs on SOF, resyncs on edges, bounds each frame, issues the
// R_frame sample tick and hands the received byte downstream.
module can_rx_seq_ctrl #(
  parameter int unsigned BIT_CLKS   = 16,
  parameter int unsigned SAMPLE_PT  = 11,
  parameter int unsigned SJW        = 2,
  parameter int unsigned IDLE_BITS  = 11,
  parameter int unsigned FRAME_BITS = 96,
  parameter int unsigned DRAIN_BITS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              Can_rx,
  input  logic              Can_data_ready,
  input  logic [7:0]        Can_rx_data_Bus,
  output logic              R_frame,
  output logic              rx_core_rst,
  output logic              frame_active,
  output logic              overrun,
  output logic              timeout_err,
  can_rx_seq_ctrl_if.master byte_if
);

  localparam int unsigned PW = $clog2(BIT_CLKS);
  localparam int unsigned IW = $clog2(IDLE_BITS + 1);
  localparam int unsigned BW = $clog2(FRAME_BITS + 1);
  localparam int unsigned DW = $clog2(DRAIN_BITS + 1);

  localparam logic [PW-1:0] SP_P   = PW'(SAMPLE_PT);
  localparam logic [PW-1:0] SJW_P  = PW'(SJW);
  localparam logic [PW-1:0] LAST_P = PW'(BIT_CLKS - 1);
  localparam logic [PW-1:0] LATE_P = PW'(BIT_CLKS - SJW);
  localparam logic [PW-1:0] WRAP_P = PW'(BIT_CLKS - 1 - SJW);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, SOF, FRAME, DRAIN} state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n, phase_inc, phase_rs;
  logic [IW-1:0] idle_cnt, idle_cnt_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;
  logic          rs_done, rs_done_n;
  logic          sync1, sync2, rx_d, dr_d;
  logic          tick, fall, dr_rise, capture, timeout_c;
  logic          rx_core_rst_n, frame_active_n, overrun_n, byte_valid_n;
  logic [7:0]    byte_data_n, byte_data_q;
  logic          byte_valid_q;

  assign tick    = (phase == SP_P);
  assign fall    = rx_d & ~sync2;
  assign dr_rise = Can_data_ready & ~dr_d;

  // Bus synchroniser, edge-detect history and data-ready history.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      rx_d  <= 1'b1;
      dr_d  <= 1'b0;
    end else begin
      sync1 <= Can_rx;
      sync2 <= sync1;
      rx_d  <= sync2;
      dr_d  <= Can_data_ready;
    end
  end

  // Nominal phase advance and the resync target for an edge at the current phase.
  always_comb begin
    phase_inc = (phase == LAST_P) ? '0 : phase + PW'(1);
    if (phase < SP_P)
      phase_rs = phase + PW'(1) - ((phase < SJW_P) ? phase : SJW_P);
    else if (phase >= LATE_P)
      phase_rs = PW'(1);
    else if (phase == WRAP_P)
      phase_rs = '0;
    else
      phase_rs = phase + SJW_P + PW'(1);
  end

  // State and bit-timing counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= WAIT_IDLE;
      phase     <= '0;
      idle_cnt  <= '0;
      bit_cnt   <= '0;
      drain_cnt <= '0;
      rs_done   <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      idle_cnt  <= idle_cnt_n;
      bit_cnt   <= bit_cnt_n;
      drain_cnt <= drain_cnt_n;
      rs_done   <= rs_done_n;
    end
  end

  // Next state, phase adjustment and frame/drain bookkeeping.
  always_comb begin
    state_n     = state;
    phase_n     = phase_inc;
    idle_cnt_n  = '0;
    bit_cnt_n   = '0;
    drain_cnt_n = '0;
    rs_done_n   = (phase == LAST_P) ? 1'b0 : rs_done;
    capture     = 1'b0;
    timeout_c   = 1'b0;
    unique case (state)
      WAIT_IDLE: begin
        idle_cnt_n = idle_cnt;
        if (tick) idle_cnt_n = sync2 ? idle_cnt + IW'(1) : '0;
        if (idle_cnt_n == IW'(IDLE_BITS)) begin
          state_n = IDLE;
          phase_n = '0;
        end
      end
      IDLE: begin
        phase_n = '0;
        if (fall) begin
          state_n = SOF;
          phase_n = PW'(1);
        end
      end
      SOF: begin
        if (tick) begin
          if (!sync2) begin
            state_n   = FRAME;
            bit_cnt_n = BW'(1);
          end else begin
            state_n = WAIT_IDLE;
          end
        end
      end
      FRAME: begin
        bit_cnt_n = bit_cnt;
        if (tick) begin
          bit_cnt_n = bit_cnt + BW'(1);
          if (bit_cnt_n == BW'(FRAME_BITS)) state_n = DRAIN;
        end
        // Late-phase resync lands in the next bit, so only early ones block a second edge.
        if (fall && !rs_done && (phase != '0) && (phase != SP_P)) begin
          phase_n   = phase_rs;
          rs_done_n = (phase < SP_P);
        end
      end
      DRAIN: begin
        drain_cnt_n = drain_cnt;
        if (dr_rise) begin
          capture = 1'b1;
          state_n = WAIT_IDLE;
        end else if (tick) begin
          if (drain_cnt == DW'(DRAIN_BITS - 1)) begin
            timeout_c = 1'b1;
            state_n   = WAIT_IDLE;
          end else begin
            drain_cnt_n = drain_cnt + DW'(1);
          end
        end
      end
      default: state_n = WAIT_IDLE;
    endcase
    if (!enable) begin
      state_n    = WAIT_IDLE;
      idle_cnt_n = '0;
      capture    = 1'b0;
      timeout_c  = 1'b0;
    end
  end

  // Next values of the registered outputs and the byte handshake.
  always_comb begin
    rx_core_rst_n  = (state_n == WAIT_IDLE) || !enable;
    frame_active_n = (state_n == SOF) || (state_n == FRAME) || (state_n == DRAIN);
    overrun_n      = 1'b0;
    byte_data_n    = byte_data_q;
    byte_valid_n   = byte_valid_q;
    if (byte_valid_q && byte_if.byte_ready) byte_valid_n = 1'b0;
    if (capture) begin
      if (byte_valid_q && !byte_if.byte_ready) begin
        overrun_n = 1'b1;
      end else begin
        byte_data_n  = Can_rx_data_Bus;
        byte_valid_n = 1'b1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_core_rst  <= 1'b1;
      frame_active <= 1'b0;
      overrun      <= 1'b0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      rx_core_rst  <= rx_core_rst_n;
      frame_active <= frame_active_n;
      overrun      <= overrun_n;
      byte_data_q  <= byte_data_n;
      byte_valid_q <= byte_valid_n;
    end
  end

  // The sample tick and the timeout pulse must land in the tick cycle itself.
  assign R_frame            = tick & enable & ((state == SOF) | (state == FRAME));
  assign timeout_err        = timeout_c;
  assign byte_if.byte_data  = byte_data_q;
  assign byte_if.byte_valid = byte_valid_q;

endmodule

// File: tb/tb_can_rx_seq_ctrl.sv
// Directed bench for can_rx_seq_ctrl at BIT_CLKS=16, SAMPLE_PT=11, SJW=2.
module tb_can_rx_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       Can_rx;
  logic       Can_data_ready;
  logic [7:0] Can_rx_data_Bus;
  logic       R_frame, rx_core_rst, frame_active, overrun, timeout_err;

  can_rx_seq_ctrl_if bif ();

  can_rx_seq_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .Can_rx          (Can_rx),
    .Can_data_ready  (Can_data_ready),
    .Can_rx_data_Bus (Can_rx_data_Bus),
    .R_frame         (R_frame),
    .rx_core_rst     (rx_core_rst),
    .frame_active    (frame_active),
    .overrun         (overrun),
    .timeout_err     (timeout_err),
    .byte_if         (bif)
  );

  always #5 clock = ~clock;

  int cyc    = 0;
  int rf_cnt = 0;
  int rf_cyc[$];
  int n_pass  = 0;
  int n_total = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Log every sample tick with the cycle it fell in.
  always @(negedge clock) begin
    if (R_frame === 1'b1) begin
      rf_cyc.push_back(cyc);
      rf_cnt = rf_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (rx_core_rst !== 1'b0 && n < 400) begin
      cycles(1);
      n++;
    end
    chk(tag, 32'(rx_core_rst), 32'd0);
  endtask

  task automatic wait_ticks(input int target, input string tag);
    int n = 0;
    while (rf_cnt < target && n < 2000) begin
      cycles(1);
      n++;
    end
    chk(tag, 32'(rf_cnt), 32'(target));
  endtask

  int k;
  int base;

  initial begin
    reset = 1'b0; enable = 1'b1; Can_rx = 1'b1;
    Can_data_ready = 1'b0; Can_rx_data_Bus = 8'h00; bif.byte_ready = 1'b0;
    cycles(3);
    chk("rst_R_frame",      32'(R_frame),        32'd0);
    chk("rst_rx_core_rst",  32'(rx_core_rst),    32'd1);
    chk("rst_frame_active", 32'(frame_active),   32'd0);
    chk("rst_byte_data",    32'(bif.byte_data),  32'd0);
    chk("rst_byte_valid",   32'(bif.byte_valid), 32'd0);
    chk("rst_overrun",      32'(overrun),        32'd0);
    chk("rst_timeout_err",  32'(timeout_err),    32'd0);
    reset = 1'b1;

    // Startup: the 11th recessive tick is cycle 171 after release.
    cycles(171);
    chk("startup_rst_at_tick11", 32'(rx_core_rst), 32'd1);
    cycles(1);
    chk("startup_rst_released",  32'(rx_core_rst), 32'd0);
    chk("startup_no_R_frame",    32'(rf_cnt),      32'd0);

    // Frame 1: SOF alignment, 96 ticks, byte handoff.
    cycles(5);
    k = cyc; base = rf_cnt; Can_rx = 1'b0;
    cycles(46);
    chk("sof_tick0",    32'(rf_cyc[base + 0]), 32'(k + 13));
    chk("sof_tick1",    32'(rf_cyc[base + 1]), 32'(k + 29));
    chk("sof_tick2",    32'(rf_cyc[base + 2]), 32'(k + 45));
    chk("frame1_active", 32'(frame_active),    32'd1);
    Can_rx = 1'b1;
    wait_ticks(base + 96, "frame1_96_ticks");
    cycles(3);
    chk("drain1_active", 32'(frame_active), 32'd1);
    Can_data_ready = 1'b1; Can_rx_data_Bus = 8'hA5;
    cycles(1);
    chk("handoff_valid",   32'(bif.byte_valid), 32'd1);
    chk("handoff_data",    32'(bif.byte_data),  32'hA5);
    chk("handoff_inactive", 32'(frame_active),  32'd0);
    chk("handoff_core_rst", 32'(rx_core_rst),   32'd1);
    chk("handoff_no_ovr",  32'(overrun),        32'd0);
    Can_data_ready = 1'b0;
    cycles(20);
    chk("frame1_exact_96", 32'(rf_cnt), 32'(base + 96));

    // Frame 2: resync at p=3 then at p=15, then a dropped second byte.
    wait_idle("idle_before_f2");
    cycles(3);
    k = cyc; base = rf_cnt; Can_rx = 1'b0;
    cycles(20); Can_rx = 1'b1;
    cycles(15); Can_rx = 1'b0;
    cycles(15); Can_rx = 1'b1;
    cycles(15); Can_rx = 1'b0;
    cycles(15); Can_rx = 1'b1;
    chk("rs_tick_sof",   32'(rf_cyc[base + 0]), 32'(k + 13));
    chk("rs_tick_nom",   32'(rf_cyc[base + 1]), 32'(k + 29));
    chk("rs_p3_late2",   32'(rf_cyc[base + 2]), 32'(k + 47));
    chk("rs_p3_follow",  32'(rf_cyc[base + 3]), 32'(k + 63));
    chk("rs_p15_edge11", 32'(rf_cyc[base + 4]), 32'(k + 78));
    wait_ticks(base + 96, "frame2_96_ticks");
    cycles(3);
    Can_data_ready = 1'b1; Can_rx_data_Bus = 8'h3C;
    cycles(1);
    chk("ovr_pulse",      32'(overrun),        32'd1);
    chk("ovr_data_kept",  32'(bif.byte_data),  32'hA5);
    chk("ovr_valid_held", 32'(bif.byte_valid), 32'd1);
    cycles(1);
    chk("ovr_one_clock",  32'(overrun),        32'd0);
    Can_data_ready = 1'b0; bif.byte_ready = 1'b1;
    cycles(1);
    chk("accept_clears_valid", 32'(bif.byte_valid), 32'd0);
    bif.byte_ready = 1'b0;

    // Frame 3: no data-ready, timeout on the 8th drain tick.
    wait_idle("idle_before_f3");
    cycles(3);
    base = rf_cnt; Can_rx = 1'b0;
    cycles(46); Can_rx = 1'b1;
    wait_ticks(base + 96, "frame3_96_ticks");
    cycles(127);
    chk("to_pulse",        32'(timeout_err),  32'd1);
    chk("to_rst_still_0",  32'(rx_core_rst),  32'd0);
    cycles(1);
    chk("to_one_clock",    32'(timeout_err),  32'd0);
    chk("to_rst_next_clk", 32'(rx_core_rst),  32'd1);
    chk("to_inactive",     32'(frame_active), 32'd0);

    // Frame 4: 4-clock glitch in IDLE.
    wait_idle("idle_before_f4");
    cycles(3);
    base = rf_cnt; Can_rx = 1'b0;
    cycles(4); Can_rx = 1'b1;
    chk("glitch_sof_active", 32'(frame_active), 32'd1);
    cycles(10);
    chk("glitch_core_rst",   32'(rx_core_rst),  32'd1);
    chk("glitch_inactive",   32'(frame_active), 32'd0);
    cycles(30);
    chk("glitch_one_tick",   32'(rf_cnt),       32'(base + 1));

    // Frame 5: enable drop suppresses R_frame in the same clock.
    wait_idle("idle_before_f5");
    cycles(3);
    Can_rx = 1'b0;
    cycles(29);
    chk("en_tick_present",  32'(R_frame), 32'd1);
    enable = 1'b0;
    #1;
    chk("en_tick_suppressed", 32'(R_frame), 32'd0);
    cycles(1);
    chk("en_core_rst",  32'(rx_core_rst),  32'd1);
    chk("en_inactive",  32'(frame_active), 32'd0);
    enable = 1'b1; Can_rx = 1'b1;

    // Frame 6: reset mid-frame.
    wait_idle("idle_before_f6");
    cycles(3);
    Can_rx = 1'b0;
    cycles(20);
    chk("midrst_pre_active", 32'(frame_active), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_inactive",  32'(frame_active),   32'd0);
    chk("midrst_core_rst",  32'(rx_core_rst),    32'd1);
    chk("midrst_byte_data", 32'(bif.byte_data),  32'd0);
    chk("midrst_R_frame",   32'(R_frame),        32'd0);
    cycles(2);
    reset = 1'b1; Can_rx = 1'b1;
    cycles(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
